// File: rtl/given_cache_control.sv
// given_cache_control: hit/writeback/allocate sequencer for a direct-mapped write-back cache.
// Define CACHE_PERF_CNT_EN to enable the saturating hit/miss/writeback counters.
module given_cache_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit,
    input  logic                 dirty_out,
    output logic                 tag_load,
    output logic                 valid_load,
    output logic                 dirty_load,
    output logic                 dirty_in,
    output logic [1:0]           writing,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    state_t state_q, state_d;
    logic req;
    assign req = mem_read | mem_write;
    always_comb begin
        state_d    = state_q;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        tag_load   = 1'b0;
        valid_load = 1'b0;
        dirty_load = 1'b0;
        dirty_in   = 1'b0;
        writing    = 2'b10;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        // a simultaneous read+write is serviced as a write
                        if (mem_write) begin
                            writing    = 2'b01;
                            dirty_load = 1'b1;
                            dirty_in   = 1'b1;
                        end
                    end else if (req) begin
                        state_d = dirty_out ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    if (pmem_resp) begin
                        dirty_load = 1'b1;
                        state_d    = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        writing    = 2'b00;
                        tag_load   = 1'b1;
                        valid_load = 1'b1;
                        dirty_load = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
`ifdef CACHE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d, wb_count_q, wb_count_d;
    logic fill_q, fill_d;
    // fill_q marks the IDLE cycle right after a fill, whose hit is not a true hit
    always_comb begin
        fill_d       = (state_q == ALLOCATE) && pmem_resp;
        hit_count_d  = hit_count_q + CNT_WIDTH'((state_q == IDLE) && req && hit && !fill_q && !(&hit_count_q));
        miss_count_d = miss_count_q + CNT_WIDTH'((state_q == IDLE) && (state_d != IDLE) && !(&miss_count_q));
        wb_count_d   = wb_count_q + CNT_WIDTH'((state_q == WRITEBACK) && pmem_resp && !(&wb_count_q));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q       <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            fill_q       <= fill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif
endmodule

// File: tb/tb_given_cache_control.sv
// tb_given_cache_control: randomized scoreboard bench with a datapath/pmem environment
// and an abstract cache reference model (valid/tag/dirty per set, event counts).
module tb_given_cache_control;
    localparam int W    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0, rst = 1'b1, mem_read = 1'b0, mem_write = 1'b0;
    logic mem_resp, pmem_read, pmem_write, pmem_resp, hit, dirty_out;
    logic tag_load, valid_load, dirty_load, dirty_in;
    logic [1:0] writing;
    logic [W-1:0] hit_count, miss_count, wb_count;
    logic [31:0] addr = 32'h0;

    always #5 clk = ~clk;

    given_cache_control #(.CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit(hit), .dirty_out(dirty_out), .tag_load(tag_load), .valid_load(valid_load),
        .dirty_load(dirty_load), .dirty_in(dirty_in), .writing(writing),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    // datapath arrays driven by the controller pins
    logic [15:0] ev, ed;
    logic [22:0] et [16];
    assign hit       = ev[addr[8:5]] && (et[addr[8:5]] == addr[31:9]);
    assign dirty_out = ed[addr[8:5]];
    always @(posedge clk) begin
        if (rst) begin
            ev <= '0;
            ed <= '0;
        end else begin
            if (tag_load)   et[addr[8:5]] <= addr[31:9];
            if (valid_load) ev[addr[8:5]] <= 1'b1;
            if (dirty_load) ed[addr[8:5]] <= dirty_in;
        end
    end

    // physical memory: answers each request after lat_next wait cycles
    int lat_next = 2;
    int wait_q = 0;
    logic busy = 1'b0;
    initial pmem_resp = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            pmem_resp <= 1'b0;
        end else begin
            pmem_resp <= 1'b0;
            if (!busy && (pmem_read || pmem_write) && !pmem_resp) begin
                busy   <= 1'b1;
                wait_q <= lat_next;
            end else if (busy) begin
                if (wait_q <= 1) begin
                    pmem_resp <= 1'b1;
                    busy      <= 1'b0;
                end else wait_q <= wait_q - 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int x);
`ifdef CACHE_PERF_CNT_EN
        return (x > MAXV) ? MAXV : x;
`else
        return 0;
`endif
    endfunction

    typedef struct {
        int issue;
        bit hit;
        bit wb;
        bit wr;
        int eh, em, ew;
    } exp_t;
    exp_t q[$];

    // reference model
    bit [15:0] rv, rdy;
    logic [22:0] rt [16];
    int nh = 0, nm = 0, nw = 0;
    task automatic model_reset();
        rv = '0; rdy = '0; nh = 0; nm = 0; nw = 0;
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input int gap);
        exp_t e;
        int idx;
        bit seen;
        idx = int'(a[8:5]);
        mem_read = rd; mem_write = wr; addr = a;
        e.issue = cyc;
        e.wr    = wr;
        e.hit   = rv[idx] && (rt[idx] == a[31:9]);
        e.wb    = !e.hit && rv[idx] && rdy[idx];
        e.eh    = sat(nh);
        if (e.hit) begin
            nh++;
            if (wr) rdy[idx] = 1'b1;
        end else begin
            nm++;
            if (e.wb) nw++;
            rv[idx] = 1'b1; rt[idx] = a[31:9]; rdy[idx] = wr;
        end
        e.em = sat(nm);
        e.ew = sat(nw);
        q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = mem_resp;
        end
        if (!seen) begin
            chk("resp_timeout", 0, 1);
            q.delete();
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // monitor: tracks pmem traffic and checks each CPU completion against the scoreboard
    initial begin
        int pcyc, rdn, wbn;
        exp_t e;
        pcyc = 0; rdn = 0; wbn = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pcyc = 0; rdn = 0; wbn = 0;
            end else begin
                if (pmem_read && pmem_write) chk("pmem_both", 1, 0);
                if (pmem_read || pmem_write) pcyc++;
                if (pmem_resp && pmem_write) begin
                    wbn++;
                    chk("wb_dirty_load", dirty_load, 1);
                    chk("wb_dirty_in", dirty_in, 0);
                    chk("wb_tag_load", tag_load, 0);
                end
                if (pmem_resp && pmem_read) begin
                    rdn++;
                    chk("fill_writing", writing, 0);
                    chk("fill_tag_load", tag_load, 1);
                    chk("fill_valid_load", valid_load, 1);
                    chk("fill_dirty_load", dirty_load, 1);
                    chk("fill_dirty_in", dirty_in, 0);
                end
                if (mem_resp) begin
                    if (q.size() == 0) chk("spurious_resp", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("latency", cyc - e.issue, e.hit ? 0 : pcyc + 1);
                        chk("fills", rdn, e.hit ? 0 : 1);
                        chk("writebacks", wbn, e.wb ? 1 : 0);
                        chk("resp_writing", writing, e.wr ? 1 : 2);
                        chk("resp_dirty_load", dirty_load, e.wr ? 1 : 0);
                        chk("resp_dirty_in", dirty_in, e.wr ? 1 : 0);
                        chk("resp_tag_load", tag_load, 0);
                        chk("hit_count", hit_count, e.eh);
                        chk("miss_count", miss_count, e.em);
                        chk("wb_count", wb_count, e.ew);
                    end
                    pcyc = 0; rdn = 0; wbn = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int op, tg, idx;
        model_reset();
        mem_write = 1'b1;
        addr = 32'h40;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mem_resp", mem_resp, 0);
            chk("rst_pmem_read", pmem_read, 0);
            chk("rst_pmem_write", pmem_write, 0);
            chk("rst_writing", writing, 2);
            chk("rst_dirty_load", dirty_load, 0);
        end
        chk("rst_hit_count", hit_count, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_write = 1'b0;
        lat_next = 2;
        do_req(1'b1, 1'b0, 32'h0000_0040, 1);
        do_req(1'b1, 1'b0, 32'h0000_0040, 1);
        do_req(1'b0, 1'b1, 32'h0000_0040, 1);
        do_req(1'b1, 1'b0, 32'h0000_0240, 1);

        // reset in the middle of a fill
        lat_next = 4;
        mem_read = 1'b1; addr = 32'h0000_0060;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = pmem_read;
        end
        chk("alloc_reached", seen, 1);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        chk("rst_drop_pmem_read", pmem_read, 0);
        chk("rst_mem_resp_mid", mem_resp, 0);
        chk("rst_clr_hit", hit_count, 0);
        chk("rst_clr_miss", miss_count, 0);
        chk("rst_clr_wb", wb_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // saturation: one fill then five hits
        lat_next = 1;
        do_req(1'b1, 1'b0, 32'h0000_0040, 0);
        repeat (5) do_req(1'b1, 1'b0, 32'h0000_0040, 0);
        @(negedge clk);
        chk("hit_saturate", hit_count, sat(nh));
        chk("miss_after_sat", miss_count, sat(nm));

        for (int n = 0; n < 300; n++) begin
            tg  = $urandom_range(0, 3);
            idx = $urandom_range(0, 15);
            op  = $urandom_range(0, 9);
            lat_next = $urandom_range(1, 4);
            do_req(op < 5 || op == 9, op >= 5, {23'(tg), 4'(idx), 5'($urandom)}, $urandom_range(0, 2));
        end
        @(negedge clk);
        chk("final_hit_count", hit_count, sat(nh));
        chk("final_miss_count", miss_count, sat(nm));
        chk("final_wb_count", wb_count, sat(nw));
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
